// File: rtl/poly_horner_eval.sv
// poly_horner_eval: sequential fixed-point polynomial evaluator.
// Evaluates y(x) by Horner iteration, one multiply-accumulate per clock.
// coef[0] is the highest power and coef[DEGREE] is the constant term.
// Coefficients and y share one Q format; x carries X_FRAC fractional bits.

module poly_horner_eval #(
  parameter int unsigned DEGREE = 5,
  parameter int unsigned X_W    = 16,
  parameter int unsigned X_FRAC = 14,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              coef_wr,
  input  logic [$clog2(DEGREE+1)-1:0]       coef_addr,
  input  logic signed [COEF_W-1:0]          coef_data,
  output logic                              coef_err,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [X_W-1:0]             x,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [ACC_W-1:0]           y,
  output logic                              sat
);

  localparam int unsigned AW = $clog2(DEGREE + 1);
  // Full-precision product width and one guard bit for the coefficient add.
  localparam int unsigned PW = ACC_W + X_W;
  localparam int unsigned SW = PW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  // Programmable bank, plus a snapshot taken when x is accepted so a write
  // landing in the acceptance cycle does not disturb the running evaluation.
  logic signed [COEF_W-1:0] coef_q [DEGREE+1];
  logic signed [COEF_W-1:0] eval_q [DEGREE+1];

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [X_W-1:0]    x_q;
  logic [AW-1:0]            k_q;
  logic                     sat_q;
  logic                     coef_err_q;

  logic                     accept;
  logic                     coef_addr_ok;
  logic                     coef_we;

  logic signed [PW-1:0]     acc_ext;
  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     shifted;
  logic signed [COEF_W-1:0] coef_k;
  logic signed [SW-1:0]     sum;
  logic signed [SW-1:0]     sat_max;
  logic signed [SW-1:0]     sat_min;
  logic signed [ACC_W-1:0]  step_acc;
  logic                     step_sat;

  assign accept       = in_valid && (state_q == StIdle);
  assign coef_addr_ok = (coef_addr <= AW'(DEGREE));
  assign coef_we      = coef_wr && (state_q == StIdle) && coef_addr_ok;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: accept in IDLE, iterate DEGREE steps, hold until drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StRun;
      StRun:  if (k_q == AW'(DEGREE)) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Coefficient bank writes; anything outside IDLE or out of range is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= int'(DEGREE); i++) begin
        coef_q[i] <= '0;
      end
      coef_err_q <= 1'b0;
    end else begin
      if (coef_we) begin
        coef_q[coef_addr] <= coef_data;
      end
      coef_err_q <= coef_wr && !coef_we;
    end
  end

  // One Horner step: acc*x rescaled by floor shift, plus the next coefficient,
  // clamped to the accumulator range.
  always_comb begin
    acc_ext  = PW'(acc_q);
    x_ext    = PW'(x_q);
    prod     = acc_ext * x_ext;
    shifted  = prod >>> X_FRAC;
    coef_k   = eval_q[k_q];
    sum      = SW'(shifted) + SW'(coef_k);
    sat_max  = '0;
    sat_max[ACC_W-2:0] = '1;
    sat_min  = '1;
    sat_min[ACC_W-2:0] = '0;
    step_sat = 1'b0;
    if (sum > sat_max) begin
      step_acc = sat_max[ACC_W-1:0];
      step_sat = 1'b1;
    end else if (sum < sat_min) begin
      step_acc = sat_min[ACC_W-1:0];
      step_sat = 1'b1;
    end else begin
      step_acc = sum[ACC_W-1:0];
    end
  end

  // Datapath registers: load on acceptance, update once per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      x_q   <= '0;
      k_q   <= '0;
      sat_q <= 1'b0;
      for (int i = 0; i <= int'(DEGREE); i++) begin
        eval_q[i] <= '0;
      end
    end else if (accept) begin
      acc_q <= ACC_W'(coef_q[0]);
      x_q   <= x;
      k_q   <= AW'(1);
      sat_q <= 1'b0;
      for (int i = 0; i <= int'(DEGREE); i++) begin
        eval_q[i] <= coef_q[i];
      end
    end else if (state_q == StRun) begin
      acc_q <= step_acc;
      sat_q <= sat_q || step_sat;
      k_q   <= k_q + AW'(1);
    end
  end

  // All outputs are decodes of registered state; acc stays frozen in DONE.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign y         = acc_q;
  assign sat       = sat_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// Directed bench for poly_horner_eval at DEGREE=2: a 32-bit accumulator
// instance and a 20-bit instance share every input.

module tb_poly_horner_eval;

  localparam int DEGREE = 2;
  localparam int ACC_W  = 32;
  localparam int ACC_S  = 20;

  logic               clk = 1'b0;
  logic               reset;
  logic               coef_wr;
  logic [1:0]         coef_addr;
  logic signed [17:0] coef_data;
  logic               in_valid;
  logic signed [15:0] x;
  logic               out_ready;

  logic               coef_err, in_ready, out_valid, sat;
  logic signed [ACC_W-1:0] y;
  logic               coef_err_s, in_ready_s, out_valid_s, sat_s;
  logic signed [ACC_S-1:0] y_s;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [ACC_W-1:0] y_cap;
  logic signed [ACC_S-1:0] ys_cap;
  logic                    sat_cap, sats_cap;

  always #5 clk = ~clk;

  poly_horner_eval #(
    .DEGREE(DEGREE), .X_W(16), .X_FRAC(14), .COEF_W(18), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .sat(sat)
  );

  poly_horner_eval #(
    .DEGREE(DEGREE), .X_W(16), .X_FRAC(14), .COEF_W(18), .ACC_W(ACC_S)
  ) dut_s (
    .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err_s), .in_valid(in_valid),
    .in_ready(in_ready_s), .x(x), .out_valid(out_valid_s), .out_ready(out_ready),
    .y(y_s), .sat(sat_s)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Golden Horner model with floor shift and saturation at the given width.
  function automatic longint horner(input longint xv, input longint c0, input longint c1,
                                    input longint c2, input int accw);
    longint acc, t, mx, mn;
    longint c [3];
    c[0] = c0; c[1] = c1; c[2] = c2;
    mx  = (longint'(1) <<< (accw - 1)) - 1;
    mn  = -(longint'(1) <<< (accw - 1));
    acc = c[0];
    for (int k = 1; k <= 2; k++) begin
      t = ((acc * xv) >>> 14) + c[k];
      if (t > mx) t = mx;
      if (t < mn) t = mn;
      acc = t;
    end
    return acc;
  endfunction

  task automatic write_coef(input logic [1:0] a, input logic signed [17:0] d);
    coef_wr = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  task automatic set3(input logic signed [17:0] c0, input logic signed [17:0] c1,
                      input logic signed [17:0] c2);
    write_coef(2'd0, c0);
    write_coef(2'd1, c1);
    write_coef(2'd2, c2);
  endtask

  task automatic start(input logic signed [15:0] xv);
    x = xv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; coef_wr = 1'b0;
  endtask

  // Wait for the result, hold it for 'hold' cycles of backpressure, then drain.
  task automatic finish(input string tag, input int exp_lat, input int hold);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    y_cap = y; ys_cap = y_s; sat_cap = sat; sats_cap = sat_s;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " y held"}, y, y_cap);
      check({tag, " in_ready low"}, in_ready, 0);
      check({tag, " out_valid held"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic signed [15:0] xs [5];
    int acc_idx, res_idx, last, cyc;
    logic rdy;
    xs = '{-16'sd32768, -16'sd1, 16'sd0, 16'sd1, 16'sd32767};

    reset = 1'b1; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; x = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset y", y, 0);
    check("reset sat", sat, 0);
    check("reset coef_err", coef_err, 0);
    check("reset in_ready_s", in_ready_s, 1);
    check("reset out_valid_s", out_valid_s, 0);
    check("reset coef_err_s", coef_err_s, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic: 0.5^2 in Q14
    set3(16384, 0, 0);
    start(8192);
    finish("basic", DEGREE, 0);
    check("basic y", y_cap, 4096);
    check("basic sat", sat_cap, 0);

    // Sign handling and floor truncation
    set3(0, 16384, 0);
    start(-8192);
    finish("sign", DEGREE, 0);
    check("sign y", y_cap, -8192);
    set3(0, 1, 0);
    start(-16384);
    finish("floor", DEGREE, 0);
    check("floor y", y_cap, -1);

    // Saturation on the 20-bit instance; the 32-bit one stays in range
    set3(131071, 131071, 131071);
    start(32767);
    finish("satur", DEGREE, 0);
    check("satur y_s", ys_cap, 524287);
    check("satur sat_s", sats_cap, 1);
    check("satur y32", y_cap, 917457);
    check("satur sat32", sat_cap, 0);
    set3(16384, 0, 0);
    start(8192);
    finish("after sat", DEGREE, 0);
    check("after sat y_s", ys_cap, 4096);
    check("after sat sat_s", sats_cap, 0);

    // Backpressure
    start(8192);
    finish("bp", DEGREE, 5);
    check("bp y", y_cap, 4096);

    // Write during RUN is dropped
    start(8192);
    coef_wr = 1'b1; coef_addr = 2'd0; coef_data = 18'sd0;
    @(posedge clk); #1;
    coef_wr = 1'b0;
    check("run wr coef_err", coef_err, 1);
    finish("run wr", DEGREE - 1, 0);
    check("run wr y", y_cap, 4096);
    start(8192);
    finish("reeval", DEGREE, 0);
    check("reeval y", y_cap, 4096);

    // Out-of-range address in IDLE
    coef_wr = 1'b1; coef_addr = 2'd3; coef_data = 18'sd777;
    @(posedge clk); #1;
    coef_wr = 1'b0;
    check("bad addr coef_err", coef_err, 1);
    @(posedge clk); #1;
    check("bad addr pulse end", coef_err, 0);

    // Write in the acceptance cycle: applied, but this evaluation sees the old value
    coef_wr = 1'b1; coef_addr = 2'd1; coef_data = 18'sd5000;
    start(8192);
    finish("same cyc", DEGREE, 0);
    check("same cyc y", y_cap, 4096);
    start(8192);
    finish("new bank", DEGREE, 0);
    check("new bank y", y_cap, 6596);

    // Reset mid-RUN clears the result and the bank
    start(8192);
    reset = 1'b1;
    #1;
    check("mid reset out_valid", out_valid, 0);
    check("mid reset in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    start(8192);
    finish("post reset", DEGREE, 0);
    check("post reset y", y_cap, 0);
    check("post reset sat", sat_cap, 0);

    // Back-to-back sweep against the golden model
    set3(-3, 100, -7);
    in_valid = 1'b1; out_ready = 1'b1; x = xs[0];
    acc_idx = 0; res_idx = 0; last = 0; cyc = 0;
    while (res_idx < 5 && cyc < 100) begin
      rdy = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy && acc_idx < 5) begin
        acc_idx++;
        if (acc_idx < 5) x = xs[acc_idx];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check("sweep y", y, horner(longint'(xs[res_idx]), -3, 100, -7, ACC_W));
        check("sweep y_s", y_s, horner(longint'(xs[res_idx]), -3, 100, -7, ACC_S));
        if (res_idx > 0) check("sweep interval", cyc - last, 4);
        last = cyc;
        res_idx++;
      end
    end
    check("sweep count", res_idx, 5);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/poly_horner_eval.md
Name: poly_horner_eval

Overview:
- Sequential fixed-point polynomial evaluator. Inverse direction of the least-squares fitter: takes a coefficient set and produces y(x) by Horner iteration, one multiply-accumulate per clock.
- Coefficient order matches the fitter output: coef[0] is the highest power and coef[DEGREE] is the constant.
- Used as the per-sample polynomial stage of the Farrow filter datapath and as a bench checker for fitted coefficients.

Parameters:
- DEGREE, 5, polynomial degree; the block holds DEGREE+1 coefficients, DEGREE >= 1.
- X_W, 16, signed width of x.
- X_FRAC, 14, fractional bits of x.
- COEF_W, 18, signed width of each coefficient.
- ACC_W, 32, signed accumulator and result width; must be >= COEF_W. Coefficients and y share one Q format.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  $clog2(DEGREE+1)  coefficient index; 0 is the highest power.
- coef_data  in  COEF_W  signed coefficient value.
- coef_err  out  1  one-cycle pulse when a write is dropped.
- in_valid  in  1  x is valid.
- in_ready  out  1  block can accept x.
- x  in  X_W  signed evaluation point.
- out_valid  out  1  result is valid.
- out_ready  in  1  sink accepts the result.
- y  out  ACC_W  signed result.
- sat  out  1  at least one Horner step saturated for this result; qualified by out_valid.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all coefficient registers, acc, x_reg, k, y and sat clear to 0; in_ready=1; out_valid=0; coef_err=0.
- Coefficient bank:
  - A write takes effect when coef_wr=1, state=IDLE and coef_addr<=DEGREE.
  - A write is dropped, with coef_err pulsing high the next cycle, in either case:
    - state is RUN or DONE;
    - coef_addr>DEGREE.
  - A write in the same cycle as an accepted x is applied; the evaluation uses the pre-write value for that address.
- FSM states:
  - IDLE: in_ready=1.
    - On in_valid=1: x_reg<=x, acc<=sign-extended coef[0], k<=1, sat_acc<=0, go to RUN.
  - RUN: in_ready=0. Each cycle:
    - p = acc*x_reg, full precision (ACC_W+X_W bits);
    - t = (p >>> X_FRAC) + sign-extended coef[k], arithmetic shift, i.e. floor truncation, no rounding;
    - acc<=sat(t): saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; sat_acc is set if clamping occurred;
    - k<=k+1;
    - when k==DEGREE, go to DONE after this update.
  - DONE: out_valid=1, y=acc, sat=sat_acc.
    - y and sat are held stable while out_ready=0.
    - On out_ready=1, go to IDLE.
- Latency: x accepted at cycle T gives out_valid first high at T+DEGREE+1.
- Throughput: one result per DEGREE+2 cycles with out_ready held high. No acceptance in DONE; no overlap.
- Outputs are registered; no combinational path from in_valid or out_ready to any output.
- Reset asserted mid-RUN or mid-DONE: the result is discarded, the block returns to IDLE, and coefficients clear. Coefficients must be rewritten after any reset.
- in_valid held high while not ready: no effect; x is sampled only in IDLE.

Test Plan (DEGREE=2, X_FRAC=14, COEF_W=18, ACC_W=32 unless stated):
- Basic: coefs {16384,0,0}, x=8192 (0.5) -> y=4096, sat=0; out_valid high exactly 3 cycles after acceptance.
- Sign and floor: coefs {0,16384,0}, x=-8192 -> y=-8192. Then coefs {0,1,0}, x=-16384 -> y=-1 (floor, not 0).
- Saturation (ACC_W=20): coefs {131071,131071,131071}, x=32767 -> y=524287, sat=1. The next evaluation with coefs {16384,0,0}, x=8192 -> y=4096, sat=0.
- Backpressure and write blocking:
  - out_ready held low 5 cycles -> y stable and in_ready=0 throughout.
  - coef_wr during RUN -> coef_err pulses, and a re-evaluation shows the bank unchanged.
  - coef_addr=3 in IDLE -> coef_err pulses.
- Reset mid-operation: assert reset in the RUN cycle -> out_valid=0 and in_ready=1 immediately. A new x with no rewrite -> y=0.
- Back-to-back: with out_ready=1 and in_valid=1 continuously, sweep x over {-32768, -1, 0, 1, 32767} against coefs {-3, 100, -7} -> results match a bench golden Horner model (same floor/saturate rules) bit-exactly, one result every 4 cycles.
